// File: rtl/trace_dump_ctrl_pkg.sv
// Shared constants for the run/trace/dump controller: record kinds,
// controller state encoding and the packed trace record layout.
package trace_dump_pkg;

    localparam logic [1:0] KIND_REG  = 2'd0;
    localparam logic [1:0] KIND_MEM  = 2'd1;
    localparam logic [1:0] KIND_DUMP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Record packs as {cycle, kind, addr, data}, data in the low bits.
    function automatic int rec_width(input int cyc_w, input int mem_aw, input int data_w);
        return cyc_w + 2 + mem_aw + data_w;
    endfunction

endpackage

// File: rtl/trace_dump_ctrl_if.sv
// Trace record stream (valid/ready) from the controller to the debug sink.
interface trace_dump_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12,
    parameter int CYC_W  = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_kind;
    logic [CYC_W-1:0]  out_cycle;
    logic [MEM_AW-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid, out_kind, out_cycle, out_addr, out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_kind, out_cycle, out_addr, out_data,
        output out_ready
    );
endinterface

// File: rtl/trace_dump_ctrl_fifo.sv
// Trace FIFO: up to two ordered pushes and one pop per edge, with registered
// occupancy and free-space counts so the stall decision has no long path.
module trace_fifo #(
    parameter int W     = 62,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clock,
    input  logic          clr_n,
    input  logic          push0,
    input  logic [W-1:0]  data0,
    input  logic          push1,
    input  logic [W-1:0]  data1,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free
);
    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] free_r;
    logic [AW-1:0] slot1_s;
    logic [CW-1:0] n_push_s;
    logic [CW-1:0] n_pop_s;

    // Second push lands behind the first when both fire together.
    always_comb begin
        slot1_s  = push0 ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        n_push_s = CW'(push0) + CW'(push1);
        n_pop_s  = CW'(pop);
    end

    // Storage array, no reset needed on payload.
    always_ff @(posedge clock) begin
        if (push0) mem_r[wr_ptr_r] <= data0;
        if (push1) mem_r[slot1_s]  <= data1;
    end

    // Pointers and counters with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clr_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            free_r   <= CW'(DEPTH);
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(n_push_s);
            rd_ptr_r <= rd_ptr_r + AW'(n_pop_s);
            count_r  <= count_r + n_push_s - n_pop_s;
            free_r   <= free_r - n_push_s + n_pop_s;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign free  = free_r;
endmodule

// File: rtl/trace_dump_ctrl.sv
// Run/trace/dump controller: runs the CPU for a set number of cycles, traces
// register and memory writes, then streams the whole register file out.
module trace_dump_ctrl
    import trace_dump_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int MEM_AW     = 12,
    parameter int CYC_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic              cpu_rwe,
    input  logic [REG_AW-1:0] cpu_rd,
    input  logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_mwe,
    input  logic [MEM_AW-1:0] cpu_maddr,
    input  logic [DATA_W-1:0] cpu_mdata,
    input  logic [REG_AW-1:0] cpu_rs1,
    output logic [REG_AW-1:0] rf_rs1,
    input  logic [DATA_W-1:0] rf_regA,
    output logic              cpu_run,
    trace_dump_ctrl_if.master tr,
    output logic              busy,
    output logic              done
);
    localparam int REC_W    = rec_width(CYC_W, MEM_AW, DATA_W);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_LSB = DATA_W;
    localparam int KIND_LSB = DATA_W + MEM_AW;
    localparam int CYC_LSB  = KIND_LSB + 2;

    state_t            state_r, state_nxt_s;
    logic [CYC_W-1:0]  lim_r, lim_nxt_s;
    logic [CYC_W-1:0]  cyc_r, cyc_nxt_s;
    logic [REG_AW-1:0] idx_r, idx_nxt_s;
    logic              run_s, push_reg_s, push_mem_s, pop_s, empty_s;
    logic [REC_W-1:0]  rec_reg_s, rec_mem_s, head_s;
    logic [CW-1:0]     count_s, free_s;

    assign rec_reg_s = {cyc_r, KIND_REG, MEM_AW'(cpu_rd), cpu_rdata};
    assign rec_mem_s = {cyc_r, KIND_MEM, cpu_maddr, cpu_mdata};
    assign empty_s   = (count_s == CW'(0));

    trace_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .clr_n (reset),
        .push0 (push_reg_s),
        .data0 (rec_reg_s),
        .push1 (push_mem_s),
        .data1 (rec_mem_s),
        .pop   (pop_s),
        .head  (head_s),
        .count (count_s),
        .free  (free_s)
    );

    // Next-state, trace pushes and stream output selection.
    always_comb begin
        state_nxt_s   = state_r;
        lim_nxt_s     = lim_r;
        cyc_nxt_s     = cyc_r;
        idx_nxt_s     = idx_r;
        run_s         = 1'b0;
        push_reg_s    = 1'b0;
        push_mem_s    = 1'b0;
        pop_s         = 1'b0;
        rf_rs1        = cpu_rs1;
        tr.out_valid  = 1'b0;
        tr.out_kind   = KIND_REG;
        tr.out_cycle  = '0;
        tr.out_addr   = '0;
        tr.out_data   = '0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lim_nxt_s   = num_cycles;
                    cyc_nxt_s   = '0;
                    state_nxt_s = (num_cycles == '0) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                // Two free slots guarantee a same-edge REG+MEM pair always fits.
                run_s = (free_s >= CW'(2));
                if (run_s) begin
                    push_reg_s = cpu_rwe && (cpu_rd != '0);
                    push_mem_s = cpu_mwe;
                    cyc_nxt_s  = cyc_r + CYC_W'(1);
                    if (cyc_nxt_s == lim_r) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    cyc_nxt_s = cyc_r;
                end
            end
            ST_DRAIN: begin
                if (empty_s) begin
                    state_nxt_s = ST_DUMP;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DUMP: begin
                rf_rs1       = idx_r;
                tr.out_valid = 1'b1;
                tr.out_kind  = KIND_DUMP;
                tr.out_addr  = MEM_AW'(idx_r);
                tr.out_data  = rf_regA;
                if (tr.out_ready) begin
                    idx_nxt_s   = idx_r + REG_AW'(1);
                    state_nxt_s = (idx_r == {REG_AW{1'b1}}) ? ST_DONE : ST_DUMP;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (state_r != ST_DUMP && !empty_s) begin
            tr.out_valid = 1'b1;
            tr.out_kind  = head_s[KIND_LSB +: 2];
            tr.out_cycle = head_s[CYC_LSB +: CYC_W];
            tr.out_addr  = head_s[ADDR_LSB +: MEM_AW];
            tr.out_data  = head_s[0 +: DATA_W];
            pop_s        = tr.out_ready;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Controller state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            lim_r   <= '0;
            cyc_r   <= '0;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            lim_r   <= lim_nxt_s;
            cyc_r   <= cyc_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    assign cpu_run = run_s;
    assign busy    = (state_r == ST_RUN) || (state_r == ST_DRAIN) || (state_r == ST_DUMP);
    assign done    = (state_r == ST_DONE);
endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Directed bench for trace_dump_ctrl: records accepted stream beats into a
// queue and compares them with hand-computed traces and register dumps.
module tb_trace_dump_ctrl;
    localparam int DATA_W = 32, REG_AW = 5, MEM_AW = 12, CYC_W = 16, FIFO_DEPTH = 8;

    typedef logic [61:0] rec_t;

    logic              clock = 1'b0;
    logic              reset, start;
    logic [CYC_W-1:0]  num_cycles;
    logic              cpu_rwe, cpu_mwe;
    logic [REG_AW-1:0] cpu_rd, cpu_rs1, rf_rs1;
    logic [DATA_W-1:0] cpu_rdata, cpu_mdata, rf_regA;
    logic [MEM_AW-1:0] cpu_maddr;
    logic              cpu_run, busy, done;
    int                n_checks = 0;
    int                n_fail   = 0;
    rec_t              recs[$];

    trace_dump_ctrl_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW), .CYC_W(CYC_W)) tr_if ();

    trace_dump_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW),
                      .CYC_W(CYC_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .cpu_rwe(cpu_rwe), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
        .cpu_mwe(cpu_mwe), .cpu_maddr(cpu_maddr), .cpu_mdata(cpu_mdata),
        .cpu_rs1(cpu_rs1), .rf_rs1(rf_rs1), .rf_regA(rf_regA),
        .cpu_run(cpu_run), .tr(tr_if), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Register file stand-in: register i holds C0DE_0000 + i.
    assign rf_regA = 32'hC0DE_0000 + 32'(rf_rs1);

    // Capture each beat the sink accepts (pop happens on the next rising edge).
    always @(negedge clock) begin
        if (reset && tr_if.out_valid && tr_if.out_ready)
            recs.push_back({tr_if.out_kind, tr_if.out_cycle, tr_if.out_addr, tr_if.out_data});
    end

    function automatic rec_t mk(input logic [1:0] k, input logic [15:0] c,
                                input logic [11:0] a, input logic [31:0] d);
        return {k, c, a, d};
    endfunction

    function automatic rec_t rec_at(input int i);
        if (i < recs.size()) return recs[i];
        else return '1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input logic [CYC_W-1:0] n);
        num_cycles = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic check_dumps(input int base);
        check("record_count", 64'(recs.size()), 64'(base + 32));
        for (int i = 0; i < 32; i++)
            check($sformatf("dump%0d", i), 64'(rec_at(base + i)),
                  64'(mk(2'd2, 16'd0, 12'(i), 32'hC0DE_0000 + 32'(i))));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; num_cycles = '0;
        cpu_rwe = 1'b0; cpu_rd = '0; cpu_rdata = '0;
        cpu_mwe = 1'b0; cpu_maddr = '0; cpu_mdata = '0;
        cpu_rs1 = 5'd7; tr_if.out_ready = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(tr_if.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_run", 64'(cpu_run), 64'd0);
        check("rst_rs1", 64'(rf_rs1), 64'd7);
        check("rst_fields", 64'({tr_if.out_kind, tr_if.out_cycle, tr_if.out_addr, tr_if.out_data}), 64'd0);
        reset = 1'b1;
        tick();

        // Single REG write at run cycle 2
        recs.delete();
        tr_if.out_ready = 1'b1;
        start_run(16'd5);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_run", 64'(cpu_run), 64'd1);
        tick(); tick();
        cpu_rwe = 1'b1; cpu_rd = 5'd3; cpu_rdata = 32'd42;
        tick();
        cpu_rwe = 1'b0;
        wait_done(200);
        check("t1_reg", 64'(rec_at(0)), 64'(mk(2'd0, 16'd2, 12'd3, 32'd42)));
        check_dumps(1);
        check("t1_done_valid", 64'(tr_if.out_valid), 64'd0);
        check("t1_done_busy", 64'(busy), 64'd0);

        // rd = 0 writes are filtered
        recs.delete();
        cpu_rwe = 1'b1; cpu_rd = 5'd0; cpu_rdata = 32'd99;
        start_run(16'd4);
        wait_done(200);
        cpu_rwe = 1'b0;
        check_dumps(0);

        // Simultaneous REG and MEM writes at run cycle 1
        recs.delete();
        start_run(16'd3);
        tick();
        cpu_rwe = 1'b1; cpu_rd = 5'd5; cpu_rdata = 32'hFFFF_FFFF;
        cpu_mwe = 1'b1; cpu_maddr = 12'd100; cpu_mdata = 32'd7;
        tick();
        cpu_rwe = 1'b0; cpu_mwe = 1'b0;
        wait_done(200);
        check("t3_reg", 64'(rec_at(0)), 64'(mk(2'd0, 16'd1, 12'd5, 32'hFFFF_FFFF)));
        check("t3_mem", 64'(rec_at(1)), 64'(mk(2'd1, 16'd1, 12'd100, 32'd7)));
        check_dumps(2);

        // Backpressure: stall once fewer than two slots are free
        recs.delete();
        tr_if.out_ready = 1'b0;
        cpu_rwe = 1'b1; cpu_rd = 5'd9; cpu_rdata = 32'h55;
        start_run(16'd20);
        for (int i = 0; i < 6; i++) tick();
        check("t4_run_free2", 64'(cpu_run), 64'd1);
        tick();
        check("t4_stall_free1", 64'(cpu_run), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t4_stall_hold", 64'(cpu_run), 64'd0);
        check("t4_head_cycle", 64'(tr_if.out_cycle), 64'd0);
        check("t4_none_accepted", 64'(recs.size()), 64'd0);
        tr_if.out_ready = 1'b1;
        wait_done(400);
        cpu_rwe = 1'b0;
        for (int i = 0; i < 20; i++)
            check($sformatf("t4_reg%0d", i), 64'(rec_at(i)), 64'(mk(2'd0, 16'(i), 12'd9, 32'h55)));
        check_dumps(20);

        // Zero-length run, dump under toggling ready
        recs.delete();
        tr_if.out_ready = 1'b1;
        start_run(16'd0);
        check("t5_drain_busy", 64'(busy), 64'd1);
        check("t5_drain_run", 64'(cpu_run), 64'd0);
        check("t5_drain_valid", 64'(tr_if.out_valid), 64'd0);
        tick();
        tr_if.out_ready = 1'b0;
        check("t5_dump0", 64'({tr_if.out_valid, tr_if.out_kind, tr_if.out_addr, tr_if.out_data}),
              64'({1'b1, 2'd2, 12'd0, 32'hC0DE_0000}));
        check("t5_rs1_idx", 64'(rf_rs1), 64'd0);
        tick();
        check("t5_hold0", 64'({tr_if.out_addr, tr_if.out_data}), 64'({12'd0, 32'hC0DE_0000}));
        tr_if.out_ready = 1'b1;
        tick();
        tr_if.out_ready = 1'b0;
        check("t5_hold1", 64'({tr_if.out_addr, tr_if.out_data}), 64'({12'd1, 32'hC0DE_0001}));
        for (int t = 0; t < 200 && !done; t++) begin
            tr_if.out_ready = (t % 3 != 0);
            tick();
        end
        check("t5_done", 64'(done), 64'd1);
        check_dumps(0);

        // Reset in the middle of the dump, then a fresh run
        tr_if.out_ready = 1'b1;
        start_run(16'd0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("t6_idx10", 64'(tr_if.out_addr), 64'd10);
        cpu_rs1 = 5'd9;
        reset = 1'b0;
        tick();
        check("t6_rst_state", 64'({tr_if.out_valid, busy, done, cpu_run}), 64'd0);
        check("t6_rst_rs1", 64'(rf_rs1), 64'd9);
        reset = 1'b1;
        tick();
        recs.delete();
        cpu_mwe = 1'b1; cpu_maddr = 12'd55; cpu_mdata = 32'h1234;
        start_run(16'd2);
        tick();
        cpu_mwe = 1'b0;
        wait_done(200);
        check("t6_mem", 64'(rec_at(0)), 64'(mk(2'd1, 16'd0, 12'd55, 32'h1234)));
        check_dumps(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trace_dump_ctrl.md
Name: trace_dump_ctrl

Overview:
Synthesizable run/trace/dump controller that sits between the processor, the register file and a debug sink. It runs the processor for a programmed number of cycles and captures every register write (rd != 0) and memory write into a trace FIFO with cycle stamps. When the run completes, it takes over regfile read port A and streams out the full register contents. All records leave on one valid/ready stream, and the processor is stalled whenever the trace cannot be accepted, so no record is ever lost.

Parameters:
DATA_W, 32, data width of registers and memory words
REG_AW, 5, regfile address width; dump covers 2**REG_AW registers
MEM_AW, 12, memory address width carried in MEM records
CYC_W, 16, cycle counter and num_cycles width
FIFO_DEPTH, 8, trace FIFO entries; power of two, >= 4

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a run; honoured only in IDLE or DONE
num_cycles  in  CYC_W  run length, sampled when start is accepted
cpu_rwe  in  1  processor regfile write enable
cpu_rd  in  REG_AW  processor write register
cpu_rdata  in  DATA_W  processor write data
cpu_mwe  in  1  processor memory write enable
cpu_maddr  in  MEM_AW  processor memory address
cpu_mdata  in  DATA_W  processor memory write data
cpu_rs1  in  REG_AW  processor read address A
rf_rs1  out  REG_AW  read address A driven to regfile
rf_regA  in  DATA_W  regfile read data A (combinational read)
cpu_run  out  1  processor clock enable; 0 = stall
out_valid  out  1  record valid
out_ready  in  1  sink accepts record
out_kind  out  2  0=REG, 1=MEM, 2=DUMP
out_cycle  out  CYC_W  run cycle of the event (0 for DUMP)
out_addr  out  MEM_AW  register number (zero-extended) or memory address
out_data  out  DATA_W  written/dumped value
busy  out  1  state is RUN, DRAIN or DUMP
done  out  1  state is DONE

Behaviour:
- States: IDLE, RUN, DRAIN, DUMP, DONE.
- Reset (reset=0 at an edge) from any state: go to IDLE, clear FIFO and counters. All outputs read 0, except rf_rs1, which equals cpu_rs1.
- IDLE/DONE: on start=1, latch num_cycles into lim, clear cyc, and go to RUN. If lim==0, go directly to DRAIN.
- RUN: cpu_run = (free >= 2), where free is the registered FIFO free count.
  - At each edge with cpu_run=1:
    - If cpu_rwe && cpu_rd != 0, push REG{cyc, cpu_rd, cpu_rdata}.
    - If cpu_mwe, push MEM{cyc, cpu_maddr, cpu_mdata}.
    - Then cyc++.
  - When both writes occur in one cycle, both are pushed in that edge, with REG ahead of MEM.
  - When cyc reaches lim after the increment, go to DRAIN.
  - Stall cycles do not advance cyc.
- DRAIN: cpu_run=0. The FIFO keeps popping. When the FIFO is empty, go to DUMP with idx=0.
- FIFO output: out_valid = !empty, and out_* = head entry. A pop occurs on out_valid && out_ready. Push and pop may happen in the same edge, and pushing 2 while popping 1 is legal.
- DUMP:
  - cpu_run=0 and rf_rs1=idx.
  - out_valid=1, out_kind=2, out_cycle=0, out_addr=idx, out_data=rf_regA. All fields stay stable while out_ready=0.
  - On acceptance, idx++. After idx = 2**REG_AW-1 is accepted, go to DONE.
- Register 0 is dumped like any other register.
- Outside DUMP, rf_rs1 = cpu_rs1.
- DONE: done=1, cpu_run=0, out_valid=0. This state holds until start or reset.
- start in RUN, DRAIN or DUMP is ignored.
- Same-edge state changes do not lose records: REG and MEM records pushed on the final RUN edge are emitted in DRAIN.

Decomposition:
- Package trace_dump_pkg holds:
  - the KIND_REG/KIND_MEM/KIND_DUMP constants;
  - the state encoding;
  - the record layout (CYC_W + 2 + MEM_AW + DATA_W bits).
- One sub-module, trace_fifo: a dual-push (ordered), single-pop synchronous FIFO with registered count/free outputs and synchronous active-low clear.

Test Plan:
- Single REG write: num_cycles=5, cpu_rwe=1 with rd=3, rdata=42 at run cycle 2, out_ready=1 → exactly one record REG{cycle=2, addr=3, data=42}. Then 32 DUMP records with addr 0..31, then done=1.
- rd=0 write filter: cpu_rwe=1 with rd=0 every cycle → no REG records.
- Simultaneous writes: cpu_rwe with rd=5, data=-1 and cpu_mwe with addr=100, data=7, same cycle → REG record immediately followed by MEM{addr=100, data=7}, both carrying the same cycle.
- Backpressure: out_ready=0 while a write occurs on every cycle, FIFO_DEPTH=8 → cpu_run drops once free<2 and stays 0. cyc freezes. When out_ready goes to 1, all events emerge in order, with cycle values 0..N-1 having no gaps.
- Dump stall and zero-length run: num_cycles=0 → FIFO-empty → DUMP. Toggling out_ready mid-dump → idx and out_data stay stable while out_ready=0, and no register is skipped or duplicated.
- Reset mid-DUMP: reset=0 at idx=10 → next edge gives IDLE, out_valid=0, rf_rs1=cpu_rs1. A following start begins a fresh run.
